// File: rtl/rv32i_inst_encoder.sv
// RV32I instruction encoder: packs operation index plus register/immediate fields
// into a 32-bit word, with one output register stage and a wrapping word address.
module rv32i_inst_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  op_sel,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [12:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_addr,
   output logic        err,
   output logic [7:0]  err_cnt,
   output logic        wrap
);

   localparam int IDX_W = $clog2(DEPTH);

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_IALU   = 7'b0010011;
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_CSR    = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_X, FMT_B, FMT_I, FMT_SH, FMT_R, FMT_L, FMT_S, FMT_C
   } fmt_t;

   fmt_t        fmt;
   logic [2:0]  funct3;
   logic        alt;
   logic [31:0] inst_enc;
   logic        illegal;
   logic        sext_ok;

   logic             out_valid_q, out_valid_d;
   logic [31:0]      out_inst_q, out_inst_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic             err_q, err_d;
   logic [7:0]       err_cnt_q, err_cnt_d;
   logic             wrap_q, wrap_d;
   logic             accept;
   logic             out_hs;

   // Operation index -> instruction format, funct3 and the bit-30 modifier.
   always_comb begin
      fmt    = FMT_X;
      funct3 = 3'b000;
      alt    = 1'b0;
      case (op_sel)
         6'd0:  begin fmt = FMT_B;  funct3 = 3'b000; end
         6'd1:  begin fmt = FMT_B;  funct3 = 3'b001; end
         6'd2:  begin fmt = FMT_B;  funct3 = 3'b100; end
         6'd3:  begin fmt = FMT_B;  funct3 = 3'b101; end
         6'd4:  begin fmt = FMT_B;  funct3 = 3'b110; end
         6'd5:  begin fmt = FMT_B;  funct3 = 3'b111; end
         6'd6:  begin fmt = FMT_I;  funct3 = 3'b000; end
         6'd7:  begin fmt = FMT_I;  funct3 = 3'b010; end
         6'd8:  begin fmt = FMT_I;  funct3 = 3'b011; end
         6'd9:  begin fmt = FMT_I;  funct3 = 3'b100; end
         6'd10: begin fmt = FMT_I;  funct3 = 3'b110; end
         6'd11: begin fmt = FMT_I;  funct3 = 3'b111; end
         6'd12: begin fmt = FMT_SH; funct3 = 3'b001; end
         6'd13: begin fmt = FMT_SH; funct3 = 3'b101; end
         6'd14: begin fmt = FMT_SH; funct3 = 3'b101; alt = 1'b1; end
         6'd15: begin fmt = FMT_R;  funct3 = 3'b000; end
         6'd16: begin fmt = FMT_R;  funct3 = 3'b000; alt = 1'b1; end
         6'd17: begin fmt = FMT_R;  funct3 = 3'b001; end
         6'd18: begin fmt = FMT_R;  funct3 = 3'b010; end
         6'd19: begin fmt = FMT_R;  funct3 = 3'b011; end
         6'd20: begin fmt = FMT_R;  funct3 = 3'b100; end
         6'd21: begin fmt = FMT_R;  funct3 = 3'b101; end
         6'd22: begin fmt = FMT_R;  funct3 = 3'b101; alt = 1'b1; end
         6'd23: begin fmt = FMT_R;  funct3 = 3'b110; end
         6'd24: begin fmt = FMT_R;  funct3 = 3'b111; end
         6'd25: begin fmt = FMT_L;  funct3 = 3'b000; end
         6'd26: begin fmt = FMT_L;  funct3 = 3'b001; end
         6'd27: begin fmt = FMT_L;  funct3 = 3'b010; end
         6'd28: begin fmt = FMT_L;  funct3 = 3'b100; end
         6'd29: begin fmt = FMT_L;  funct3 = 3'b101; end
         6'd30: begin fmt = FMT_S;  funct3 = 3'b000; end
         6'd31: begin fmt = FMT_S;  funct3 = 3'b001; end
         6'd32: begin fmt = FMT_S;  funct3 = 3'b010; end
         6'd33: begin fmt = FMT_C;  funct3 = 3'b001; end
         6'd34: begin fmt = FMT_C;  funct3 = 3'b010; end
         6'd35: begin fmt = FMT_C;  funct3 = 3'b011; end
         6'd36: begin fmt = FMT_C;  funct3 = 3'b101; end
         6'd37: begin fmt = FMT_C;  funct3 = 3'b110; end
         6'd38: begin fmt = FMT_C;  funct3 = 3'b111; end
         default: fmt = FMT_X;
      endcase
   end

   // Shift amounts count as I-type too, so imm[12:5] must all be zero.
   always_comb begin
      inst_enc = 32'h0;
      illegal  = 1'b0;
      sext_ok  = (imm[12] == imm[11]);
      case (fmt)
         FMT_B: begin
            inst_enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
            illegal  = imm[0];
         end
         FMT_I: begin
            inst_enc = {imm[11:0], rs1, funct3, rd, OPC_IALU};
            illegal  = !sext_ok;
         end
         FMT_SH: begin
            inst_enc = {1'b0, alt, 5'b00000, imm[4:0], rs1, funct3, rd, OPC_IALU};
            illegal  = |imm[12:5];
         end
         FMT_R: inst_enc = {1'b0, alt, 5'b00000, rs2, rs1, funct3, rd, OPC_R};
         FMT_L: begin
            inst_enc = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            illegal  = !sext_ok;
         end
         FMT_S: begin
            inst_enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            illegal  = !sext_ok;
         end
         FMT_C:   inst_enc = {imm[11:0], rs1, funct3, rd, OPC_CSR};
         default: illegal  = 1'b1;
      endcase
   end

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign out_hs   = out_valid_q && out_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      out_inst_d  = out_inst_q;
      index_d     = out_hs ? index_q + IDX_W'(1) : index_q;
      err_d       = accept && illegal;
      wrap_d      = out_hs && (index_q == IDX_W'(DEPTH - 1));
      err_cnt_d   = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
      // A rejected request in the handshake cycle still empties the register.
      if (accept && !illegal) begin
         out_valid_d = 1'b1;
         out_inst_d  = inst_enc;
      end else if (out_hs) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_inst_q  <= 32'h0;
         index_q     <= '0;
         err_q       <= 1'b0;
         err_cnt_q   <= 8'h00;
         wrap_q      <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_inst_q  <= out_inst_d;
         index_q     <= index_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
         wrap_q      <= wrap_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_inst  = out_inst_q;
   assign out_addr  = BASE_ADDR + 32'({index_q, 2'b00});
   assign err       = err_q;
   assign err_cnt   = err_cnt_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Bench for rv32i_inst_encoder: directed literal vectors plus randomized traffic
// checked every cycle against a transaction-level model of the encoder.
module tb_rv32i_inst_encoder;

   localparam int DEPTH = 4;
   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  op_sel = '0;
   logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
   logic [12:0] imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_addr;
   logic        err;
   logic [7:0]  err_cnt;
   logic        wrap;

   int total = 0;
   int bad = 0;

   rv32i_inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_addr(out_addr),
      .err(err), .err_cnt(err_cnt), .wrap(wrap)
   );

   always #5 clk = ~clk;

   // funct3 of each legal op index, in op_sel order.
   int f3_tab [0:38] = '{0,1,4,5,6,7, 0,2,3,4,6,7,1,5,5, 0,0,1,2,3,4,5,5,6,7,
                         0,1,2,4,5, 0,1,2, 1,2,3,5,6,7};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference encoder working on integer field values and a signed immediate.
   function automatic void model_enc(input int op, input int d, input int s1, input int s2,
                                     input int im, output logic [31:0] w, output bit ill);
      longint r;
      int sv, f3;
      sv  = (im >= 4096) ? im - 8192 : im;
      ill = 0;
      r   = 0;
      if (op > 38) begin
         ill = 1;
      end else begin
         f3 = f3_tab[op];
         if (op <= 5) begin
            ill = (sv % 2) != 0;
            r = ((im >> 12) & 1) * 2**31 + ((im >> 5) & 63) * 2**25 + s2 * 2**20 + s1 * 2**15
              + f3 * 2**12 + ((im >> 1) & 15) * 2**8 + ((im >> 11) & 1) * 2**7 + 'h63;
         end else if (op >= 12 && op <= 14) begin
            ill = (sv < 0) || (sv > 31);
            r = ((op == 14) ? 2**30 : 0) + (im & 31) * 2**20 + s1 * 2**15 + f3 * 2**12 + d * 2**7 + 'h13;
         end else if (op <= 11 || (op >= 25 && op <= 29)) begin
            ill = (sv < -2048) || (sv > 2047);
            r = (im & 4095) * 2**20 + s1 * 2**15 + f3 * 2**12 + d * 2**7 + ((op <= 11) ? 'h13 : 'h03);
         end else if (op <= 24) begin
            r = ((op == 16 || op == 22) ? 2**30 : 0) + s2 * 2**20 + s1 * 2**15 + f3 * 2**12 + d * 2**7 + 'h33;
         end else if (op <= 32) begin
            ill = (sv < -2048) || (sv > 2047);
            r = ((im >> 5) & 127) * 2**25 + s2 * 2**20 + s1 * 2**15 + f3 * 2**12 + (im & 31) * 2**7 + 'h23;
         end else begin
            r = (im & 4095) * 2**20 + s1 * 2**15 + f3 * 2**12 + d * 2**7 + 'h73;
         end
      end
      w = 32'(r);
   endfunction

   // Model state: what the outputs must show after the most recent edge.
   bit          m_valid = 0;
   logic [31:0] m_inst = '0;
   int          m_idx = 0;
   bit          m_err = 0;
   bit          m_wrap = 0;
   int          m_cnt = 0;

   initial begin
      logic [31:0] w;
      bit ill, acc, hs;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_valid = 0; m_inst = '0; m_idx = 0; m_err = 0; m_wrap = 0; m_cnt = 0;
         end else begin
            model_enc(int'(op_sel), int'(rd), int'(rs1), int'(rs2), int'(imm), w, ill);
            acc = in_valid && (!m_valid || out_ready);
            hs  = m_valid && out_ready;
            if (hs) $display("word out: addr=%h inst=%h", BASE + 32'(4 * m_idx), m_inst);
            m_err  = acc && ill;
            m_wrap = hs && (m_idx == DEPTH - 1);
            if (m_err && m_cnt < 255) m_cnt++;
            if (hs) m_idx = (m_idx + 1) % DEPTH;
            if (acc && !ill) begin
               m_valid = 1;
               m_inst  = w;
            end else if (hs) begin
               m_valid = 0;
            end
         end
         @(negedge clk);
         chk("model out_valid", 32'(out_valid), 32'(m_valid));
         chk("model in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
         chk("model out_addr", out_addr, BASE + 32'(4 * m_idx));
         chk("model err", 32'(err), 32'(m_err));
         chk("model err_cnt", 32'(err_cnt), 32'(m_cnt));
         chk("model wrap", 32'(wrap), 32'(m_wrap));
         if (m_valid) chk("model out_inst", out_inst, m_inst);
      end
   end

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit v, input int op, input int d, input int s1, input int s2,
                        input int im, input bit ordy);
      in_valid  = v;
      op_sel    = 6'(op);
      rd        = 5'(d);
      rs1       = 5'(s1);
      rs2       = 5'(s2);
      imm       = 13'(im);
      out_ready = ordy;
   endtask

   task automatic rand_drive();
      int op, im, k, v;
      op = ($urandom_range(0, 19) == 0) ? int'($urandom_range(39, 63)) : int'($urandom_range(0, 38));
      k  = int'($urandom_range(0, 3));
      if (op <= 5) begin
         im = int'($urandom_range(0, 8191));
         if (k != 0) im = im & ~1;
      end else if (op >= 12 && op <= 14) begin
         im = (k == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 31));
         if (((im >> 5) & 127) == 0) im = im & 31;
      end else begin
         v  = int'($urandom_range(0, 4095));
         im = (k == 0) ? int'($urandom_range(0, 8191)) : ((v >= 2048) ? v + 4096 : v);
      end
      drive($urandom_range(0, 3) != 0, op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), im, $urandom_range(0, 9) < 7);
   endtask

   initial begin
      rst = 1'b1;
      nxt();
      nxt();
      @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_inst", out_inst, 32'd0);
      chk("reset out_addr", out_addr, BASE);
      chk("reset err_cnt", 32'(err_cnt), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      nxt();
      rst = 1'b0;

      // Back-to-back legal words; the fifth wraps the DEPTH=4 index.
      drive(1, 6, 1, 0, 0, 5, 1);
      nxt(); drive(1, 16, 3, 1, 2, 0, 1);
      @(negedge clk); chk("addi inst", out_inst, 32'h00500093); chk("addi addr", out_addr, 32'h0);
      nxt(); drive(1, 0, 0, 1, 2, 8, 1);
      @(negedge clk); chk("sub inst", out_inst, 32'h402081B3); chk("sub addr", out_addr, 32'h4);
      nxt(); drive(1, 32, 0, 2, 5, 12, 1);
      @(negedge clk); chk("beq inst", out_inst, 32'h00208463); chk("beq addr", out_addr, 32'h8);
      nxt(); drive(1, 14, 4, 4, 0, 3, 1);
      @(negedge clk); chk("sw inst", out_inst, 32'h00512623); chk("sw addr", out_addr, 32'hC);
      nxt(); drive(1, 36, 1, 5, 0, 'h300, 1);
      @(negedge clk); chk("srai inst", out_inst, 32'h40325213); chk("srai addr", out_addr, 32'h0);
      chk("wrap pulse", 32'(wrap), 32'd1);
      nxt(); drive(0, 0, 0, 0, 0, 0, 1);
      @(negedge clk); chk("csrrwi inst", out_inst, 32'h3002D0F3); chk("csrrwi addr", out_addr, 32'h4);
      chk("wrap single", 32'(wrap), 32'd0);
      nxt();
      @(negedge clk); chk("drained", 32'(out_valid), 32'd0);

      // Backpressure: word A held five cycles while B waits at the input.
      nxt(); drive(1, 6, 2, 3, 0, 'h1FFF, 0);
      nxt(); drive(1, 15, 5, 6, 7, 0, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall in_ready", 32'(in_ready), 32'd0);
         chk("stall inst", out_inst, 32'hFFF18113);
         chk("stall addr", out_addr, 32'h8);
         nxt();
      end
      out_ready = 1'b1;
      nxt(); drive(0, 0, 0, 0, 0, 0, 1);
      @(negedge clk); chk("after stall inst", out_inst, 32'h007302B3); chk("after stall addr", out_addr, 32'hC);
      nxt();

      // Illegal requests: error pulse, count, no word, no address move.
      begin
         int eops [4] = '{45, 0, 12, 6};
         int eims [4] = '{0, 7, 32, 'h0800};
         for (int i = 0; i < 4; i++) begin
            drive(1, eops[i], 1, 1, 1, eims[i], 1);
            nxt(); drive(0, 0, 0, 0, 0, 0, 1);
            @(negedge clk);
            chk("illegal err", 32'(err), 32'd1);
            chk("illegal err_cnt", 32'(err_cnt), 32'(i + 1));
            chk("illegal no word", 32'(out_valid), 32'd0);
            chk("illegal addr", out_addr, 32'h0);
            nxt();
            @(negedge clk);
            chk("err one cycle", 32'(err), 32'd0);
            nxt();
         end
      end
      drive(1, 50, 0, 0, 0, 0, 1);
      repeat (296) nxt();
      drive(0, 0, 0, 0, 0, 0, 1);
      @(negedge clk); chk("err_cnt saturate", 32'(err_cnt), 32'd255);
      nxt();

      repeat (1500) begin
         rand_drive();
         nxt();
      end

      // Reset while a word is waiting on the consumer.
      drive(1, 15, 1, 2, 3, 0, 0);
      nxt(); drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); chk("pre-reset valid", 32'(out_valid), 32'd1);
      nxt(); rst = 1'b1;
      nxt(); rst = 1'b0;
      @(negedge clk);
      chk("mid reset valid", 32'(out_valid), 32'd0);
      chk("mid reset addr", out_addr, BASE);
      chk("mid reset err_cnt", 32'(err_cnt), 32'd0);
      nxt();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
